// File: rtl/axi_w_responder.sv
// -----------------------------------------------------------------------------
// axi_w_responder
//
// Receive side of an AXI4 write-data / write-response link. Beats accepted on
// the W channel are queued in a DEPTH-entry FIFO and presented to a local
// consumer. Each beat the consumer takes earns one B-channel response, and
// responses are returned in acceptance order. W-channel credit is released only
// when a response completes. This keeps the number of accepted but unanswered
// beats at or below DEPTH.
//
// Optional feature (macro AXI_W_RESP_ERR_EN):
//   Adds the recv_err input. The flag is captured on every pop into a
//   DEPTH-entry error FIFO. Each response then carries SLVERR (2'b10) when its
//   captured bit is set, and OKAY (2'b00) otherwise. Without the macro, bresp
//   is always OKAY.
//
// Parameters:
//   DEPTH      FIFO entries and maximum number of outstanding beats
//              (power of two, >= 2)
//   DATA_W     W data width
//
// Ports:
//   clk        clock; all logic is on its rising edge
//   rst        synchronous active-high reset
//   wdata      W channel data
//   wvalid     W channel valid
//   wready     W channel ready; depends on registers and rst only
//   bresp      B channel response
//   bvalid     B channel valid
//   bready     B channel ready
//   recv_data  head-of-FIFO data to the consumer
//   recv_valid recv_data is valid
//   recv_ready consumer takes the head beat
//   recv_err   error flag for the beat being popped (AXI_W_RESP_ERR_EN only)
// -----------------------------------------------------------------------------
module axi_w_responder #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic [DATA_W-1:0] recv_data,
    output logic              recv_valid,
    input  logic              recv_ready
`ifdef AXI_W_RESP_ERR_EN
    ,
    input  logic              recv_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic {B_IDLE, B_RESP} b_state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     occ_reg, occ_next;
    logic [CW-1:0]     pend_reg, pend_next;
    logic [CW:0]       outstanding;
    logic [DATA_W-1:0] recv_data_reg, recv_data_next;
    b_state_t          b_state_reg, b_state_next;
    logic              push, pop, cmpl;

    assign push = wvalid && wready;
    assign pop  = recv_valid && recv_ready;
    assign cmpl = bvalid && bready;

    // Credit counts beats still in the FIFO plus responses still owed.
    assign outstanding = {1'b0, occ_reg} + {1'b0, pend_reg};
    assign wready      = (outstanding < DEPTH_C) && !rst;

    assign recv_valid = (occ_reg != '0);
    assign recv_data  = recv_data_reg;

    assign occ_next  = occ_reg + CW'(push) - CW'(pop);
    assign pend_next = pend_reg + CW'(pop) - CW'(cmpl);

    // Every accepted beat is stored in the RAM, including the one that is
    // currently mirrored in the head register.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Head register: load the entry that becomes the head after this cycle.
    // If the FIFO holds one beat and it is being popped while a new beat
    // arrives, the new beat goes straight to the head.
    always_comb begin
        recv_data_next = recv_data_reg;
        if (pop) begin
            if (occ_reg > CW'(1)) begin
                recv_data_next = mem[rd_ptr_reg + 1'b1];
            end else if (push) begin
                recv_data_next = wdata;
            end
        end else if ((occ_reg == '0) && push) begin
            recv_data_next = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            occ_reg       <= '0;
            pend_reg      <= '0;
            recv_data_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            occ_reg       <= occ_next;
            pend_reg      <= pend_next;
            recv_data_reg <= recv_data_next;
        end
    end

    // B-channel FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            b_state_reg <= B_IDLE;
        end else begin
            b_state_reg <= b_state_next;
        end
    end

    // B-channel FSM: next state
    always_comb begin
        b_state_next = b_state_reg;
        case (b_state_reg)
            B_IDLE: begin
                if ((pend_reg != '0) || pop) begin
                    b_state_next = B_RESP;
                end
            end
            B_RESP: begin
                // Stay busy when a pop in the same cycle refills the owed count.
                if (cmpl && (pend_next == '0)) begin
                    b_state_next = B_IDLE;
                end
            end
            default: b_state_next = B_IDLE;
        endcase
    end

`ifdef AXI_W_RESP_ERR_EN
    logic [DEPTH-1:0] err_bits_reg, err_bits_next;
    logic [AW-1:0]    err_wr_ptr_reg, err_rd_ptr_reg;

    // Error flags follow the same order as pops, so the read side only
    // advances on completions.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_err_slot
        assign err_bits_next[gi] = (pop && (err_wr_ptr_reg == AW'(gi))) ?
                                   recv_err : err_bits_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_bits_reg   <= '0;
            err_wr_ptr_reg <= '0;
            err_rd_ptr_reg <= '0;
        end else begin
            err_bits_reg <= err_bits_next;
            if (pop) begin
                err_wr_ptr_reg <= err_wr_ptr_reg + 1'b1;
            end
            if (cmpl) begin
                err_rd_ptr_reg <= err_rd_ptr_reg + 1'b1;
            end
        end
    end

    // B-channel FSM: outputs
    always_comb begin
        bvalid = (b_state_reg == B_RESP);
        bresp  = 2'b00;
        if (bvalid && err_bits_reg[err_rd_ptr_reg]) begin
            bresp = 2'b10;
        end
    end
`else
    // B-channel FSM: outputs
    always_comb begin
        bvalid = (b_state_reg == B_RESP);
        bresp  = 2'b00;
    end
`endif

endmodule

// File: tb/tb_axi_w_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_w_responder
//
// Directed bench for axi_w_responder (DEPTH=4, DATA_W=32). A short
// vector table covers the single-beat flow. Hand-written sequences cover the
// credit limit, B backpressure, full-rate streaming and reset mid-operation.
// The error-response path is covered when AXI_W_RESP_ERR_EN is defined.
// Inputs change on the falling edge. Outputs are checked 1 time unit later.
// -----------------------------------------------------------------------------
module tb_axi_w_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] recv_data;
    logic        recv_valid;
    logic        recv_ready;
`ifdef AXI_W_RESP_ERR_EN
    logic        recv_err;
`endif

    always #5 clk = ~clk;

    axi_w_responder #(.DEPTH(4), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .wdata      (wdata),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready),
        .recv_data  (recv_data),
        .recv_valid (recv_valid),
        .recv_ready (recv_ready)
`ifdef AXI_W_RESP_ERR_EN
        ,
        .recv_err   (recv_err)
`endif
    );

    typedef struct {
        logic        wvalid;
        logic [31:0] wdata;
        logic        recv_ready;
        logic        bready;
        logic        exp_wready;
        logic        exp_recv_valid;
        logic [31:0] exp_recv_data;
        logic        exp_bvalid;
        logic [1:0]  exp_bresp;
    } vec_t;

    vec_t vecs [4];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int sent;
    int stream_cycles;
    int resp_at_acc5;
    bit w_fire;

    logic [31:0] acc_q [$];
    logic [31:0] pop_q [$];
    logic [1:0]  resp_q [$];
    int          resp_cyc [$];

    // Handshake monitor. Accepts are logged before completions so that
    // resp_at_acc5 counts only responses finished on earlier edges.
    always @(posedge clk) begin
        if (!rst) begin
            if (wvalid && wready) begin
                if (acc_q.size() == 4) resp_at_acc5 = resp_q.size();
                acc_q.push_back(wdata);
            end
            if (recv_valid && recv_ready) pop_q.push_back(recv_data);
            if (bvalid && bready) begin
                resp_q.push_back(bresp);
                resp_cyc.push_back(cyc);
            end
        end
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    task automatic clear_logs();
        acc_q.delete();
        pop_q.delete();
        resp_q.delete();
        resp_cyc.delete();
    endtask

    task automatic stream(input int n, input int maxc, input logic [31:0] base);
        int c = 0;
        while (sent < n && c < maxc) begin
            wvalid = 1'b1;
            wdata  = base + sent;
            #1 w_fire = wvalid && wready;
            @(posedge clk);
            @(negedge clk);
            if (w_fire) sent++;
            c++;
        end
        stream_cycles = c;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_resp(input int n, input int maxc);
        int c = 0;
        while (resp_q.size() < n && c < maxc) begin
            @(posedge clk);
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single-beat flow, one row per cycle; expectations hold before the edge.
        vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 2'b00};
        vecs[1] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 2'b00};
        vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 2'b00};
        vecs[3] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 2'b00};

        rst        = 1'b1;
        wvalid     = 1'b1;
        wdata      = 32'hA5A5A5A5;
        recv_ready = 1'b1;
        bready     = 1'b1;
`ifdef AXI_W_RESP_ERR_EN
        recv_err   = 1'b0;
`endif

        // ---- reset values, with wvalid held high ----
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("rst_wready", wready, 0);
            chk("rst_bvalid", bvalid, 0);
            chk("rst_bresp", bresp, 0);
            chk("rst_recv_valid", recv_valid, 0);
            chk("rst_recv_data", recv_data, 0);
        end
        chk("rst_no_accept", acc_q.size(), 0);
        @(negedge clk);
        rst    = 1'b0;
        wvalid = 1'b0;
        #1 chk("post_rst_wready", wready, 1);
        @(negedge clk);

        // ---- single beat, table driven ----
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            wvalid     = vecs[i].wvalid;
            wdata      = vecs[i].wdata;
            recv_ready = vecs[i].recv_ready;
            bready     = vecs[i].bready;
            #1;
            chk($sformatf("vec%0d_wready", i), wready, vecs[i].exp_wready);
            chk($sformatf("vec%0d_recv_valid", i), recv_valid, vecs[i].exp_recv_valid);
            if (vecs[i].exp_recv_valid)
                chk($sformatf("vec%0d_recv_data", i), recv_data, vecs[i].exp_recv_data);
            chk($sformatf("vec%0d_bvalid", i), bvalid, vecs[i].exp_bvalid);
            chk($sformatf("vec%0d_bresp", i), bresp, vecs[i].exp_bresp);
            @(posedge clk);
            @(negedge clk);
        end
        chk("single_resp_count", resp_q.size(), 1);
        chk("single_pop_data", (pop_q.size() > 0) ? pop_q[0] : 32'hFFFFFFFF, 32'hDEADBEEF);

        // ---- credit limit: 6 beats offered with the consumer stalled ----
        clear_logs();
        sent         = 0;
        resp_at_acc5 = -1;
        recv_ready   = 1'b0;
        bready       = 1'b1;
        stream(6, 10, 32'd1);
        chk("credit_accepted", sent, 4);
        #1 chk("credit_wready_full", wready, 0);
        recv_ready = 1'b1;
        stream(6, 20, 32'd1);
        wvalid = 1'b0;
        wait_resp(6, 20);
        chk("credit_resp_count", resp_q.size(), 6);
        chk("credit_resp_before_beat5", resp_at_acc5, 1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("credit_pop%0d", i), (i < pop_q.size()) ? pop_q[i] : 32'hFFFFFFFF, i + 1);
            chk($sformatf("credit_bresp%0d", i), (i < resp_q.size()) ? resp_q[i] : 2'b11, 0);
        end

        // ---- B backpressure ----
        clear_logs();
        sent       = 0;
        recv_ready = 1'b1;
        bready     = 1'b0;
        stream(2, 6, 32'h100);
        wvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp_bvalid%0d", k), bvalid, 1);
            chk($sformatf("bp_bresp%0d", k), bresp, 0);
            @(posedge clk);
            @(negedge clk);
        end
        chk("bp_no_resp_while_stalled", resp_q.size(), 0);
        bready = 1'b1;
        wait_resp(2, 10);
        chk("bp_resp_count", resp_q.size(), 2);
        chk("bp_consecutive", (resp_q.size() == 2) ? resp_cyc[1] - resp_cyc[0] : -1, 1);

        // ---- full-rate stream of 16 beats ----
        clear_logs();
        sent       = 0;
        recv_ready = 1'b1;
        bready     = 1'b1;
        stream(16, 40, 32'h200);
        wvalid = 1'b0;
        chk("stream_cycles", stream_cycles, 16);
        wait_resp(16, 20);
        idle_cycles(2);
        chk("stream_resp_count", resp_q.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("stream_pop%0d", i), (i < pop_q.size()) ? pop_q[i] : 32'hFFFFFFFF, 32'h200 + i);
        #1;
        chk("stream_end_wready", wready, 1);
        chk("stream_end_recv_valid", recv_valid, 0);
        chk("stream_end_bvalid", bvalid, 0);
        // Full credit must be available again: exactly DEPTH beats accepted.
        @(negedge clk);
        sent       = 0;
        recv_ready = 1'b0;
        stream(8, 8, 32'h300);
        wvalid = 1'b0;
        chk("stream_credit_restored", sent, 4);
        recv_ready = 1'b1;
        wait_resp(16 + 4, 20);

`ifdef AXI_W_RESP_ERR_EN
        // ---- error responses 00, 10, 00 ----
        clear_logs();
        sent       = 0;
        recv_ready = 1'b0;
        bready     = 1'b0;
        stream(3, 6, 32'h400);
        wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            recv_ready = 1'b1;
            recv_err   = (k == 1);
            @(posedge clk);
            @(negedge clk);
        end
        recv_ready = 1'b0;
        recv_err   = 1'b0;
        bready     = 1'b1;
        wait_resp(3, 10);
        chk("err_resp_count", resp_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("err_bresp%0d", i), (i < resp_q.size()) ? resp_q[i] : 2'b11, (i == 1) ? 2 : 0);
        recv_ready = 1'b1;
`endif

        // ---- reset with two responses pending ----
        clear_logs();
        sent       = 0;
        recv_ready = 1'b1;
        bready     = 1'b0;
        stream(2, 6, 32'h500);
        wvalid = 1'b0;
        idle_cycles(1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("midrst_bvalid", bvalid, 0);
        bready = 1'b1;
        idle_cycles(6);
        chk("midrst_no_stale_resp", resp_q.size(), 0);
        chk("midrst_recv_valid", recv_valid, 0);
        chk("midrst_wready", wready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_w_responder.md
# axi_w_responder

Receiving end of the team's AXI4 write-data/write-response link. Accepts beats from the W channel into a small FIFO, hands them to the local consumer, and returns one B-channel response per beat once the consumer has taken that beat. Sits between an AXI W/B master and a local data sink such as a register bank or stream buffer.

## Interface
- `DEPTH`, default 4: FIFO entries and the maximum number of outstanding beats (accepted but not yet answered). Power of two, ≥ 2.
- `DATA_W`, default 32: width of W data.
- `clk` in 1: single clock. All logic is synchronous to its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `wdata` in DATA_W: AXI write data.
- `wvalid` in 1: master has a beat.
- `wready` out 1: responder can accept a beat.
- `bresp` out 2: write response.
- `bvalid` out 1: response valid.
- `bready` in 1: master accepts the response.
- `recv_data` out DATA_W: head-of-FIFO data to the consumer.
- `recv_valid` out 1: `recv_data` is valid.
- `recv_ready` in 1: consumer takes the head beat.
- `recv_err` in 1: present only with `AXI_W_RESP_ERR_EN`. Error flag for the beat being popped.

## Operation
- **Accept.** A beat is accepted when `wvalid && wready`. The beat is pushed to the FIFO tail.
- **Pop.** A beat is popped when `recv_valid && recv_ready`. Popping increments `pend`, the count of responses owed.
- **Respond.** A response completes when `bvalid && bready`. Completion decrements `pend`.
- **Credit rule.** `outstanding = occ + pend`, where `occ` is FIFO occupancy. `outstanding` never exceeds `DEPTH`.
  - `wready = (outstanding < DEPTH) && !rst`.
  - `wready` is a combinational function of registers only. It never depends on `wvalid`.
- **B-channel FSM** has two states:
  - B_IDLE → B_RESP when `pend > 0`, or when a pop occurs this cycle; `bvalid` rises the next cycle.
  - B_RESP → B_IDLE on a completion when `pend` becomes 0 after this cycle's updates. Otherwise it stays in B_RESP, and `bvalid` remains high with the next `bresp`.
- **bresp value.** `bresp` is `2'b00` (OKAY), except as described under Configuration.
- **Stability.** `bresp` and `bvalid` are held stable while `bvalid && !bready`.
- **Simultaneous events.**
  - Push and pop in the same cycle: `occ` is unchanged.
  - Pop and completion in the same cycle: `pend` is unchanged.
  - All three in the same cycle are legal. The counters update by the sum of all effects.
- **Ordering.** Responses are returned in pop order, which equals acceptance order.
- **Reset mid-operation.** The FIFO is emptied and `pend` cleared. Any beats accepted but not yet answered are dropped; no response is ever issued for them.
- **Reset values.** `wready` 0, `bvalid` 0, `bresp` 00, `recv_valid` 0, `recv_data` 0.

## Timing
- **W to recv.** A beat accepted at edge N sets `recv_valid` in cycle N+1 (one-cycle latency). `recv_data` is registered FIFO output.
- **Pop to B.** A pop at edge M sets `bvalid` in cycle M+1. The minimum accept-to-`bvalid` latency is 2 cycles.
- **Back-to-back.** Full throughput of one beat per cycle is sustained while `recv_ready` and `bready` are held high and `DEPTH` ≥ 2.
- **After reset.** `wready` is 1 in the first cycle after `rst` deasserts.
- **Full.** When `outstanding == DEPTH`, `wready` is 0. It returns to 1 in the cycle after a completion.
  - A pop does not free credit; only a completion does.
- **Empty.** `recv_valid` is 0 and `recv_ready` is ignored. When `pend == 0` and no pop occurs, `bvalid` is 0.

## Configuration
- **Macro:** `AXI_W_RESP_ERR_EN`.
- **When defined:**
  - The `recv_err` port exists.
  - On each pop, `recv_err` is captured into a `DEPTH`-entry 1-bit response FIFO.
  - Each response carries `bresp = 2'b10` (SLVERR) if its captured bit is 1, and `2'b00` otherwise.
- **When undefined:**
  - No `recv_err` port and no error FIFO.
  - `bresp` is constant `2'b00`, and only the `pend` counter is kept.

## Test plan
- **Reset value check.** Hold `rst` for 3 cycles with `wvalid=1` → all outputs hold their reset values and no beat is accepted. Release `rst` → `wready=1` in the next cycle.
- **Single beat.** Send `wdata=32'hDEADBEEF` with `recv_ready=1` and `bready=1`:
  - `recv_valid=1` with `recv_data=DEADBEEF` one cycle after acceptance.
  - `bvalid=1`, `bresp=00` one cycle after the pop.
  - Exactly one response.
- **Credit limit.** `DEPTH=4`, `recv_ready=0`, send 6 beats `1..6`:
  - Exactly 4 beats accepted, then `wready=0`.
  - Set `recv_ready=1` and `bready=1` → data `1,2,3,4` is popped in order, followed by 4 OKAY responses.
  - Beats 5 and 6 are then accepted.
- **B backpressure.** Pop 2 beats with `bready=0` for 5 cycles → `bvalid` and `bresp` held stable throughout. Raise `bready` → 2 responses complete on consecutive cycles.
- **Simultaneous push/pop/complete.** Stream 16 beats with all readies high → one beat per cycle sustained and exactly 16 responses. Final state: `occ=0`, `pend=0`, `wready=1`.
- **Error response (`AXI_W_RESP_ERR_EN`).** Pop 3 beats with `recv_err = 0,1,0` → `bresp` sequence is `00, 10, 00`. Assert `rst` with 2 responses pending → `bvalid=0` next cycle and no stale responses afterwards.
